// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common-data-bus arbiter.
package cdb_arbiter_pkg;

  localparam int CDB_COUNT = 2;
  localparam int REG_W     = 6;

  typedef struct packed {
    logic        tag;
    logic [5:0]  arn;
    logic [5:0]  rrn;
    logic [31:0] result;
  } cdb_request_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Request and broadcast signals between execution units and the CDB arbiter.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REQ_CNT = 4
);
  logic                                delete_tag;
  logic                                stall;
  logic [REQ_CNT-1:0]                  req_valid;
  logic [REQ_CNT-1:0]                  req_tag;
  logic [REQ_CNT-1:0][REG_W-1:0]       req_arn;
  logic [REQ_CNT-1:0][REG_W-1:0]       req_rrn;
  logic [REQ_CNT-1:0][XLEN-1:0]        req_result;
  logic [REQ_CNT-1:0]                  req_ready;
  logic [CDB_COUNT-1:0]                cdb_valid;
  logic [CDB_COUNT-1:0][REG_W-1:0]     cdb_arn;
  logic [CDB_COUNT-1:0][REG_W-1:0]     cdb_rrn;
  logic [CDB_COUNT-1:0][XLEN-1:0]      cdb_result;

  modport slave (
    input  delete_tag, stall, req_valid, req_tag, req_arn, req_rrn, req_result,
    output req_ready, cdb_valid, cdb_arn, cdb_rrn, cdb_result
  );

  modport master (
    output delete_tag, stall, req_valid, req_tag, req_arn, req_rrn, req_result,
    input  req_ready, cdb_valid, cdb_arn, cdb_rrn, cdb_result
  );
endinterface

// File: rtl/cdb_arbiter_round_robin_picker.sv
// Combinational two-winner round-robin picker; scans from ptr and wraps mod N.
module round_robin_picker
  import cdb_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant0,
  output logic [N-1:0]  grant1,
  output logic          grant0_valid,
  output logic          grant1_valid,
  output logic [PW-1:0] next_ptr
);

  always_comb begin
    int          idx;
    logic [PW-1:0] sel;
    grant0       = '0;
    grant1       = '0;
    grant0_valid = 1'b0;
    grant1_valid = 1'b0;
    next_ptr     = ptr;
    idx          = 0;
    sel          = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      sel = PW'(idx);
      if (eligible[sel]) begin
        // next_ptr tracks the most recent winner, so it ends one past the last grant
        if (!grant0_valid) begin
          grant0[sel]  = 1'b1;
          grant0_valid = 1'b1;
          next_ptr     = PW'(wrap_inc(idx, N));
        end else if (!grant1_valid) begin
          grant1[sel]  = 1'b1;
          grant1_valid = 1'b1;
          next_ptr     = PW'(wrap_inc(idx, N));
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Grants up to two pending results per cycle onto the two common data buses.
// Optional CDB_ARB_STATS_EN adds a saturating conflict_count output.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REQ_CNT = 4
) (
  input  logic         clock,
  input  logic         reset,
  cdb_arbiter_if.slave bus
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [31:0]  conflict_count
`endif
);

  localparam int PW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

  logic [REQ_CNT-1:0]              pending, eligible, grant0, grant1;
  logic                            grant0_valid, grant1_valid;
  logic [PW-1:0]                   rr_ptr_q, rr_ptr_d, next_ptr;
  logic [CDB_COUNT-1:0][REQ_CNT-1:0] grant_vec;
  logic [CDB_COUNT-1:0]            grant_vld;

  logic [CDB_COUNT-1:0]            cdb_valid_q, cdb_valid_d;
  logic [CDB_COUNT-1:0][REG_W-1:0] cdb_arn_q, cdb_arn_d;
  logic [CDB_COUNT-1:0][REG_W-1:0] cdb_rrn_q, cdb_rrn_d;
  logic [CDB_COUNT-1:0][XLEN-1:0]  cdb_result_q, cdb_result_d;

  // Flushed speculative results are invisible; stall hides everything.
  assign pending  = bus.req_valid & ~({REQ_CNT{bus.delete_tag}} & bus.req_tag);
  assign eligible = bus.stall ? '0 : pending;

  round_robin_picker #(.N(REQ_CNT), .PW(PW)) u_picker (
    .eligible     (eligible),
    .ptr          (rr_ptr_q),
    .grant0       (grant0),
    .grant1       (grant1),
    .grant0_valid (grant0_valid),
    .grant1_valid (grant1_valid),
    .next_ptr     (next_ptr)
  );

  assign grant_vec     = {grant1, grant0};
  assign grant_vld     = {grant1_valid, grant0_valid};
  assign bus.req_ready = reset ? (grant0 | grant1) : '0;

  always_comb begin
    rr_ptr_d     = next_ptr;
    cdb_valid_d  = grant_vld;
    cdb_arn_d    = cdb_arn_q;
    cdb_rrn_d    = cdb_rrn_q;
    cdb_result_d = cdb_result_q;
    for (int b = 0; b < CDB_COUNT; b++) begin
      if (grant_vld[b]) begin
        cdb_arn_d[b]    = '0;
        cdb_rrn_d[b]    = '0;
        cdb_result_d[b] = '0;
        for (int i = 0; i < REQ_CNT; i++) begin
          if (grant_vec[b][i]) begin
            cdb_arn_d[b]    = bus.req_arn[i];
            cdb_rrn_d[b]    = bus.req_rrn[i];
            cdb_result_d[b] = bus.req_result[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q     <= '0;
      cdb_valid_q  <= '0;
      cdb_arn_q    <= '0;
      cdb_rrn_q    <= '0;
      cdb_result_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_arn_q    <= cdb_arn_d;
      cdb_rrn_q    <= cdb_rrn_d;
      cdb_result_q <= cdb_result_d;
    end
  end

  assign bus.cdb_valid  = cdb_valid_q;
  assign bus.cdb_arn    = cdb_arn_q;
  assign bus.cdb_rrn    = cdb_rrn_q;
  assign bus.cdb_result = cdb_result_q;

`ifdef CDB_ARB_STATS_EN
  logic [31:0] conflict_count_q, conflict_count_d;
  logic        conflict;

  // A stalled cycle counts too: the requester was ready to go but lost the cycle.
  assign conflict = |(pending & ~(grant0 | grant1));

  always_comb begin
    conflict_count_d = conflict_count_q;
    if (conflict && (conflict_count_q != '1)) conflict_count_d = conflict_count_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) conflict_count_q <= '0;
    else        conflict_count_q <= conflict_count_d;
  end

  assign conflict_count = conflict_count_q;
`endif

endmodule
